axis_video_frame_sink: RTL and testbench

AXIS_VIDEO_FRAME_SINK -- requirements
Module: axis_video_frame_sink

---
 rtl/axis_video_frame_sink.sv | 184 ++++++++++++++++++
 tb/tb_axis_video_frame_sink.sv | 293 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axis_video_frame_sink.sv
// AXI4-Stream video frame sink.
// Consumes one frame of IMG_WIDTH x IMG_HEIGHT pixels. It reports each completed
// frame with a checksum and a frame count, and keeps sticky line-length and
// restart error flags.
//
// Handshake: a beat is transferred on a rising ACLK edge where s_axis_tvalid and
// s_axis_tready are both 1. s_axis_tready is a registered copy of the ready
// decision for the next cycle. It is high in WAIT_SOF. It is high in ACTIVE,
// except on optional stall cycles. It is low in IDLE and DONE.
module axis_video_frame_sink #(
  parameter int DATA_WIDTH = 16,
  parameter int IMG_WIDTH  = 1920,
  parameter int IMG_HEIGHT = 1080,
  parameter int STALL_EN   = 0
) (
  input  logic                  ACLK,
  input  logic                  ARESETN,
  input  logic                  s_axis_tvalid,
  output logic                  s_axis_tready,
  input  logic [DATA_WIDTH-1:0] s_axis_tdata,
  input  logic                  s_axis_tuser,
  input  logic                  s_axis_tlast,
  input  logic                  enable,
  input  logic                  err_clear,
  output logic                  frame_done,
  output logic [15:0]           frame_count,
  output logic [31:0]           frame_checksum,
  output logic [3:0]            err_status,
  output logic [1:0]            dbg_state
);

  localparam int XW = (IMG_WIDTH  > 1) ? $clog2(IMG_WIDTH)  : 1;
  localparam int YW = (IMG_HEIGHT > 1) ? $clog2(IMG_HEIGHT) : 1;
  localparam logic [XW-1:0] X_LAST = XW'(IMG_WIDTH - 1);
  localparam logic [YW-1:0] Y_LAST = YW'(IMG_HEIGHT - 1);

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_WAIT_SOF = 2'd1,
    S_ACTIVE   = 2'd2,
    S_DONE     = 2'd3
  } state_t;

  state_t          state_q, state_d;
  logic [XW-1:0]   x_q, x_d;
  logic [YW-1:0]   y_q, y_d;
  logic [31:0]     sum_q, sum_d;
  logic [1:0]      stall_q, stall_d;
  logic            tready_q, tready_d;
  logic            done_q, done_d;
  logic [15:0]     count_q, count_d;
  logic [31:0]     cksum_q, cksum_d;
  logic [2:0]      err_q, err_d;

  // Per-beat scratch values used by the next-state logic.
  logic            accept;
  logic            take;
  logic            line_end;
  logic [XW-1:0]   beat_x;
  logic [YW-1:0]   beat_y;
  logic [31:0]     base_sum;
  logic [31:0]     pix;
  logic [2:0]      err_set;

  assign accept = s_axis_tvalid && tready_q;
  assign pix    = 32'(s_axis_tdata);

  // Next-state decode: FSM transitions, pixel/line tracking, checksum and error detection.
  always_comb begin
    state_d  = state_q;
    x_d      = x_q;
    y_d      = y_q;
    sum_d    = sum_q;
    err_set  = 3'b000;
    take     = 1'b0;
    line_end = 1'b0;
    beat_x   = x_q;
    beat_y   = y_q;
    base_sum = sum_q;

    case (state_q)
      S_IDLE: begin
        if (enable) state_d = S_WAIT_SOF;
      end
      S_WAIT_SOF: begin
        if (!enable) begin
          state_d = S_IDLE;
        end else if (accept && s_axis_tuser) begin
          // Start of frame: this beat is pixel (0,0).
          take     = 1'b1;
          beat_x   = '0;
          beat_y   = '0;
          base_sum = '0;
        end
      end
      S_ACTIVE: begin
        if (!enable) begin
          state_d = S_IDLE;
        end else if (accept) begin
          take = 1'b1;
          if (s_axis_tuser) begin
            // Unexpected start of frame: abort and restart from this beat.
            err_set[2] = 1'b1;
            beat_x     = '0;
            beat_y     = '0;
            base_sum   = '0;
          end
        end
      end
      S_DONE: begin
        state_d = enable ? S_WAIT_SOF : S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    if (take) begin
      sum_d    = base_sum + pix;
      line_end = s_axis_tlast || (beat_x == X_LAST);
      if (s_axis_tlast && (beat_x != X_LAST))  err_set[0] = 1'b1;
      if (!s_axis_tlast && (beat_x == X_LAST)) err_set[1] = 1'b1;
      if (line_end) begin
        x_d = '0;
        if (beat_y == Y_LAST) begin
          y_d     = '0;
          state_d = S_DONE;
        end else begin
          y_d     = beat_y + YW'(1);
          state_d = S_ACTIVE;
        end
      end else begin
        x_d     = beat_x + XW'(1);
        y_d     = beat_y;
        state_d = S_ACTIVE;
      end
    end
  end

  // Registered-output decode.
  // Ready and the frame report are computed from the next state, so they line up with the state register.
  always_comb begin
    stall_d  = stall_q + 2'd1;
    tready_d = (state_d == S_WAIT_SOF) ||
               ((state_d == S_ACTIVE) && !((STALL_EN != 0) && (stall_d == 2'd3)));
    done_d   = (state_d == S_DONE);
    count_d  = done_d ? (count_q + 16'd1) : count_q;
    cksum_d  = done_d ? sum_d : cksum_q;
    err_d    = (err_clear ? 3'b000 : err_q) | err_set;
  end

  // State and output registers with asynchronous reset.
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      state_q  <= S_IDLE;
      x_q      <= '0;
      y_q      <= '0;
      sum_q    <= '0;
      stall_q  <= '0;
      tready_q <= 1'b0;
      done_q   <= 1'b0;
      count_q  <= '0;
      cksum_q  <= '0;
      err_q    <= '0;
    end else begin
      state_q  <= state_d;
      x_q      <= x_d;
      y_q      <= y_d;
      sum_q    <= sum_d;
      stall_q  <= stall_d;
      tready_q <= tready_d;
      done_q   <= done_d;
      count_q  <= count_d;
      cksum_q  <= cksum_d;
      err_q    <= err_d;
    end
  end

  assign s_axis_tready  = tready_q;
  assign frame_done     = done_q;
  assign frame_count    = count_q;
  assign frame_checksum = cksum_q;
  assign err_status     = {1'b0, err_q};
  assign dbg_state      = state_q;

endmodule

// File: tb/tb_axis_video_frame_sink.sv
// Bench for axis_video_frame_sink.
// Covers a small 4x2 image with directed and random frames. The bench keeps a
// frame-level reference model: pixels of the current frame are held in a queue,
// and the expected line length, checksum and error flags are derived from it.
module tb_axis_video_frame_sink;
  localparam int DW = 16;
  localparam int IW = 4;
  localparam int IH = 2;

  logic          ACLK = 1'b0;
  logic          ARESETN = 1'b1;
  logic          s_axis_tvalid = 1'b0;
  logic [DW-1:0] s_axis_tdata = '0;
  logic          s_axis_tuser = 1'b0;
  logic          s_axis_tlast = 1'b0;
  logic          enable = 1'b0;
  logic          err_clear = 1'b0;

  logic          s_axis_tready;
  logic          frame_done;
  logic [15:0]   frame_count;
  logic [31:0]   frame_checksum;
  logic [3:0]    err_status;
  logic [1:0]    dbg_state;

  logic          ns_tready;
  logic          ns_frame_done;
  logic [15:0]   ns_frame_count;
  logic [31:0]   ns_frame_checksum;
  logic [3:0]    ns_err_status;
  logic [1:0]    ns_dbg_state;

  axis_video_frame_sink #(.DATA_WIDTH(DW), .IMG_WIDTH(IW), .IMG_HEIGHT(IH), .STALL_EN(1)) dut (
    .ACLK(ACLK), .ARESETN(ARESETN),
    .s_axis_tvalid(s_axis_tvalid), .s_axis_tready(s_axis_tready),
    .s_axis_tdata(s_axis_tdata), .s_axis_tuser(s_axis_tuser), .s_axis_tlast(s_axis_tlast),
    .enable(enable), .err_clear(err_clear),
    .frame_done(frame_done), .frame_count(frame_count),
    .frame_checksum(frame_checksum), .err_status(err_status), .dbg_state(dbg_state)
  );

  // Instance without back-pressure; only its ready behaviour in ACTIVE is observed.
  axis_video_frame_sink #(.DATA_WIDTH(DW), .IMG_WIDTH(IW), .IMG_HEIGHT(IH), .STALL_EN(0)) dut_ns (
    .ACLK(ACLK), .ARESETN(ARESETN),
    .s_axis_tvalid(s_axis_tvalid), .s_axis_tready(ns_tready),
    .s_axis_tdata(s_axis_tdata), .s_axis_tuser(s_axis_tuser), .s_axis_tlast(s_axis_tlast),
    .enable(enable), .err_clear(err_clear),
    .frame_done(ns_frame_done), .frame_count(ns_frame_count),
    .frame_checksum(ns_frame_checksum), .err_status(ns_err_status), .dbg_state(ns_dbg_state)
  );

  // Clock and reset-relative cycle count.
  always #5 ACLK = ~ACLK;

  int cyc;
  always @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) cyc <= 0;
    else          cyc <= cyc + 1;
  end

  int checks = 0;
  int errors = 0;
  int stall_seen = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Without back-pressure, ready must stay high throughout ACTIVE.
  always @(negedge ACLK) begin
    if (ARESETN && ns_dbg_state == 2'd2) check("nostall_ready", 32'(ns_tready), 32'd1);
  end

  // ---------------- reference model ----------------
  bit          m_active = 0;
  int          pos = 0;
  int          lines = 0;
  logic [31:0] frame_pix[$];
  logic [3:0]  m_err = '0;
  int          exp_count = 0;
  logic [31:0] exp_cksum = '0;
  bit          m_done = 0;

  function automatic logic [31:0] qsum();
    logic [31:0] s = '0;
    foreach (frame_pix[i]) s = s + frame_pix[i];
    return s;
  endfunction

  task automatic model_reset();
    m_active = 0; pos = 0; lines = 0; frame_pix.delete();
    m_err = '0; exp_count = 0; exp_cksum = '0; m_done = 0;
  endtask

  task automatic model_beat(input logic [DW-1:0] d, input bit u, input bit l);
    m_done = 0;
    if (err_clear) m_err = '0;
    if (u) begin
      if (m_active) m_err[2] = 1'b1;
      m_active = 1; pos = 0; lines = 0; frame_pix.delete();
    end else if (!m_active) begin
      return;
    end
    frame_pix.push_back(32'(d));
    pos++;
    if (l || pos == IW) begin
      if (l && pos < IW)   m_err[0] = 1'b1;
      if (!l && pos == IW) m_err[1] = 1'b1;
      pos = 0;
      lines++;
      if (lines == IH) begin
        m_active  = 0;
        exp_count = exp_count + 1;
        exp_cksum = qsum();
        m_done    = 1;
      end
    end
  endtask

  // ---------------- driver tasks ----------------
  // Called on a negedge; returns on the negedge after the accepting edge.
  task automatic send_beat(input logic [DW-1:0] d, input bit u, input bit l);
    bit acc;
    int guard;
    s_axis_tvalid = 1'b1; s_axis_tdata = d; s_axis_tuser = u; s_axis_tlast = l;
    acc = 0; guard = 0;
    while (!acc && guard < 40) begin
      if (m_active) begin
        check("stall_pattern", 32'(s_axis_tready), (cyc % 4 == 3) ? 32'd0 : 32'd1);
        if (cyc % 4 == 3) stall_seen++;
      end
      acc = (s_axis_tready === 1'b1);
      @(negedge ACLK);
      guard++;
    end
    s_axis_tvalid = 1'b0; s_axis_tuser = 1'b0; s_axis_tlast = 1'b0;
    if (!acc) begin
      checks++; errors++;
      $error("FAIL handshake_timeout: observed no accept expected accept within 40 cycles");
    end else begin
      model_beat(d, u, l);
    end
    check("frame_done", 32'(frame_done), 32'(m_done));
    check("err_status", 32'(err_status), 32'(m_err));
    check("frame_count", 32'(frame_count), 32'(exp_count[15:0]));
    if (m_done) check("frame_checksum", frame_checksum, exp_cksum);
  endtask

  task automatic idle(input int n);
    s_axis_tvalid = 1'b0;
    repeat (n) begin
      @(negedge ACLK);
      check("idle_frame_done", 32'(frame_done), 32'd0);
      check("idle_err_status", 32'(err_status), 32'(m_err));
    end
  endtask

  // Well-formed frame; seq=1 uses data 1..IW*IH, otherwise random data.
  task automatic send_frame(input bit seq, input bit gaps);
    for (int y = 0; y < IH; y++) begin
      for (int x = 0; x < IW; x++) begin
        logic [DW-1:0] d;
        d = seq ? DW'(y * IW + x + 1) : DW'($urandom_range(0, 65535));
        send_beat(d, (x == 0 && y == 0), (x == IW - 1));
        if (gaps && $urandom_range(0, 2) == 0) idle($urandom_range(1, 2));
      end
    end
  endtask

  task automatic do_err_clear();
    err_clear = 1'b1;
    @(negedge ACLK);
    err_clear = 1'b0;
    m_err = '0;
    check("err_clear", 32'(err_status), 32'd0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_tready"}, 32'(s_axis_tready), 32'd0);
    check({tag, "_done"}, 32'(frame_done), 32'd0);
    check({tag, "_count"}, 32'(frame_count), 32'd0);
    check({tag, "_cksum"}, frame_checksum, 32'd0);
    check({tag, "_err"}, 32'(err_status), 32'd0);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    int nb;
    bit first, u, l;

    #1 ARESETN = 1'b0;
    #3;
    check_reset_outputs("reset");
    @(negedge ACLK);
    @(negedge ACLK);
    ARESETN = 1'b1;
    model_reset();
    enable = 1'b1;
    idle(2);

    // Nominal frame with data 1..8.
    send_frame(1, 0);
    check("nominal_cksum", frame_checksum, 32'd36);
    check("nominal_count", 32'(frame_count), 32'd1);
    idle(1);

    // Short line 0 (three pixels), then a full line 1: seven beats in total.
    send_beat(16'd1, 1, 0); send_beat(16'd2, 0, 0); send_beat(16'd3, 0, 1);
    send_beat(16'd4, 0, 0); send_beat(16'd5, 0, 0); send_beat(16'd6, 0, 0);
    send_beat(16'd7, 0, 1);
    check("short_line_err0", 32'(err_status[0]), 32'd1);
    check("short_line_cksum", frame_checksum, 32'd28);
    do_err_clear();

    // Leading non-SOF beats are dropped in WAIT_SOF.
    send_beat(16'd100, 0, 0); send_beat(16'd200, 0, 1); send_beat(16'd300, 0, 0);
    send_frame(1, 1);
    check("lead_drop_cksum", frame_checksum, 32'd36);
    check("lead_drop_err", 32'(err_status), 32'd0);

    // Second SOF during line 1 restarts the frame.
    send_beat(16'd9, 1, 0); send_beat(16'd9, 0, 0); send_beat(16'd9, 0, 0); send_beat(16'd9, 0, 1);
    send_beat(16'd9, 0, 0);
    send_frame(1, 0);
    check("restart_err2", 32'(err_status[2]), 32'd1);
    check("restart_cksum", frame_checksum, 32'd36);
    do_err_clear();

    // Random frames with occasional line-length errors, restarts and gaps.
    for (int f = 0; f < 16; f++) begin
      nb = 0; first = 1;
      do begin
        u = first || ($urandom_range(0, 19) == 0);
        l = (pos == IW - 1) || (u && IW == 1);
        if ($urandom_range(0, 7) == 0) l = !l;
        if (u) l = ($urandom_range(0, 7) == 0) ? 1'b1 : (IW == 1);
        send_beat(DW'($urandom_range(0, 65535)), u, l);
        first = 0; nb++;
        if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 2));
      end while (!m_done && nb < 40);
      check("random_frame_completed", 32'(m_done), 32'd1);
    end

    // New error on the same edge as err_clear keeps its bit.
    send_beat(16'd11, 1, 0);
    send_beat(16'd12, 1, 0);
    err_clear = 1'b1;
    send_beat(16'd13, 0, 1);
    err_clear = 1'b0;
    check("clear_vs_new_err", 32'(err_status), 32'd1);
    send_frame(0, 0);
    do_err_clear();

    // Back-to-back frame with tvalid held high through the stalls.
    stall_seen = 0;
    send_frame(0, 0);
    check("stall_observed", 32'(stall_seen > 0), 32'd1);
    idle(1);

    // Dropping enable mid-frame discards the partial frame.
    send_beat(16'd5, 1, 0); send_beat(16'd6, 0, 0); send_beat(16'd7, 0, 0);
    enable = 1'b0;
    m_active = 0;
    @(negedge ACLK);
    check("disable_tready", 32'(s_axis_tready), 32'd0);
    idle(2);
    enable = 1'b1;
    send_frame(1, 0);
    check("after_disable_cksum", frame_checksum, 32'd36);
    check("after_disable_err", 32'(err_status), 32'd0);

    // Reset mid-frame clears everything immediately.
    send_beat(16'd1, 1, 0); send_beat(16'd2, 0, 1);
    #2 ARESETN = 1'b0;
    #1;
    check_reset_outputs("midreset");
    @(negedge ACLK);
    ARESETN = 1'b1;
    model_reset();
    idle(1);
    send_frame(0, 1);
    check("post_reset_count", 32'(frame_count), 32'd1);

    idle(3);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
